// File: rtl/route_sequencer.sv
// Control sequencer that drives the input routers, weight routers and the
// systolic array through a programmable number of weight passes.
// Each pass: route until every router is ready, stream with a one-cycle
// ready-to-pop latency, drain partial sums, then reroute/clear before the
// next pass.  All outputs come straight from flops.
module route_sequencer #(
    parameter int IR_COUNT   = 4,
    parameter int WR_COUNT   = 1,
    parameter int PASS_WIDTH = 8,
    parameter int DRAIN_CYC  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_reg_clear,
    input  logic                  i_start,
    input  logic [PASS_WIDTH-1:0] i_pass_count,
    input  logic [IR_COUNT-1:0]   i_ir_ready,
    input  logic [WR_COUNT-1:0]   i_wr_ready,
    input  logic [IR_COUNT-1:0]   i_ir_done,
    input  logic [WR_COUNT-1:0]   i_wr_done,
    output logic                  o_route_en,
    output logic                  o_pop,
    output logic                  o_pe_en,
    output logic                  o_psum_out_en,
    output logic                  o_reroute,
    output logic                  o_array_clear,
    output logic [PASS_WIDTH-1:0] o_pass_idx,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int DONE_W = IR_COUNT + WR_COUNT;
    // A drain counter of at least one bit, even when only one drain cycle is used.
    localparam int CNT_W  = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ROUTE   = 3'd1,
        S_STREAM  = 3'd2,
        S_DRAIN   = 3'd3,
        S_REROUTE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [PASS_WIDTH-1:0] pass_total_q, pass_total_d;
    logic [PASS_WIDTH-1:0] pass_idx_q, pass_idx_d;
    logic [CNT_W-1:0]      drain_cnt_q, drain_cnt_d;
    logic [DONE_W-1:0]     done_seen_q, done_seen_d;

    logic route_en_q, route_en_d;
    logic pop_q, pop_d;
    logic pe_en_q, pe_en_d;
    logic psum_q, psum_d;
    logic reroute_q, reroute_d;
    logic clear_q, clear_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic              all_ready;
    logic [DONE_W-1:0] done_merge;
    logic              all_done;
    logic              last_drain;
    logic              last_pass;

    // Readiness, sticky completion and end-of-phase conditions.
    always_comb begin
        all_ready  = (&i_ir_ready) & (&i_wr_ready);
        // The incoming done bits are merged so the set may complete in the same cycle.
        done_merge = done_seen_q | {i_ir_done, i_wr_done};
        all_done   = &done_merge;
        last_drain = (drain_cnt_q == CNT_W'(DRAIN_CYC - 1));
        // pass_total is at least 1 whenever a drain ends, so the subtraction cannot wrap.
        last_pass  = (pass_idx_q == (pass_total_q - PASS_WIDTH'(1)));
    end

    // Next-state, pass bookkeeping and registered-output next values.
    always_comb begin
        state_d      = state_q;
        pass_total_d = pass_total_q;
        pass_idx_d   = pass_idx_q;
        drain_cnt_d  = drain_cnt_q;
        done_seen_d  = done_seen_q;
        pop_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    pass_total_d = i_pass_count;
                    pass_idx_d   = '0;
                    done_seen_d  = '0;
                    state_d      = (i_pass_count == '0) ? S_DONE : S_ROUTE;
                end
            end
            S_ROUTE: begin
                done_seen_d = done_merge;
                if (all_ready) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                done_seen_d = done_merge;
                if (all_done) begin
                    // Completion beats a simultaneous ready: no further pop is issued.
                    state_d     = S_DRAIN;
                    drain_cnt_d = '0;
                end else begin
                    // A dropped ready bit simply stalls the pop; the state holds.
                    pop_d = all_ready;
                end
            end
            S_DRAIN: begin
                if (last_drain) begin
                    drain_cnt_d = '0;
                    state_d     = last_pass ? S_DONE : S_REROUTE;
                end else begin
                    drain_cnt_d = drain_cnt_q + CNT_W'(1);
                end
            end
            S_REROUTE: begin
                done_seen_d = '0;
                pass_idx_d  = pass_idx_q + PASS_WIDTH'(1);
                state_d     = S_ROUTE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the upcoming state so they line up with it.
        route_en_d = (state_d == S_ROUTE) || (state_d == S_STREAM);
        pe_en_d    = pop_q;
        psum_d     = (state_d == S_DRAIN);
        reroute_d  = (state_d == S_REROUTE);
        clear_d    = (state_d == S_REROUTE);
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
    end

    // State, counters, sticky flags and output registers; soft clear acts like reset.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_reg_clear) begin
            state_q      <= S_IDLE;
            pass_total_q <= '0;
            pass_idx_q   <= '0;
            drain_cnt_q  <= '0;
            done_seen_q  <= '0;
            route_en_q   <= 1'b0;
            pop_q        <= 1'b0;
            pe_en_q      <= 1'b0;
            psum_q       <= 1'b0;
            reroute_q    <= 1'b0;
            clear_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pass_total_q <= pass_total_d;
            pass_idx_q   <= pass_idx_d;
            drain_cnt_q  <= drain_cnt_d;
            done_seen_q  <= done_seen_d;
            route_en_q   <= route_en_d;
            pop_q        <= pop_d;
            pe_en_q      <= pe_en_d;
            psum_q       <= psum_d;
            reroute_q    <= reroute_d;
            clear_q      <= clear_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign o_route_en    = route_en_q;
    assign o_pop         = pop_q;
    assign o_pe_en       = pe_en_q;
    assign o_psum_out_en = psum_q;
    assign o_reroute     = reroute_q;
    assign o_array_clear = clear_q;
    assign o_pass_idx    = pass_idx_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;

endmodule

// File: tb/tb_route_sequencer.sv
// Testbench for route_sequencer: directed scenarios followed by random
// traffic, every cycle compared against a pass-level behavioural model.
module tb_route_sequencer;

    localparam int IR_COUNT   = 4;
    localparam int WR_COUNT   = 1;
    localparam int PASS_WIDTH = 8;
    localparam int DRAIN_CYC  = 4;

    localparam int P_IDLE = 0, P_ROUTE = 1, P_STREAM = 2, P_DRAIN = 3, P_REROUTE = 4, P_DONE = 5;

    logic                  i_clk = 1'b0;
    logic                  i_rst = 1'b1;
    logic                  i_reg_clear = 1'b0;
    logic                  i_start = 1'b0;
    logic [PASS_WIDTH-1:0] i_pass_count = '0;
    logic [IR_COUNT-1:0]   i_ir_ready = '0;
    logic [WR_COUNT-1:0]   i_wr_ready = '0;
    logic [IR_COUNT-1:0]   i_ir_done = '0;
    logic [WR_COUNT-1:0]   i_wr_done = '0;
    logic                  o_route_en, o_pop, o_pe_en, o_psum_out_en;
    logic                  o_reroute, o_array_clear, o_busy, o_done;
    logic [PASS_WIDTH-1:0] o_pass_idx;

    always #5 i_clk = ~i_clk;

    route_sequencer #(
        .IR_COUNT(IR_COUNT), .WR_COUNT(WR_COUNT),
        .PASS_WIDTH(PASS_WIDTH), .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_reg_clear(i_reg_clear), .i_start(i_start),
        .i_pass_count(i_pass_count), .i_ir_ready(i_ir_ready), .i_wr_ready(i_wr_ready),
        .i_ir_done(i_ir_done), .i_wr_done(i_wr_done), .o_route_en(o_route_en),
        .o_pop(o_pop), .o_pe_en(o_pe_en), .o_psum_out_en(o_psum_out_en),
        .o_reroute(o_reroute), .o_array_clear(o_array_clear), .o_pass_idx(o_pass_idx),
        .o_busy(o_busy), .o_done(o_done)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: current phase, passes, remaining drain cycles, seen done bits.
    int  m_phase = P_IDLE;
    int  m_total = 0;
    int  m_idx   = 0;
    int  m_drain_left = 0;
    bit  m_seen [IR_COUNT+WR_COUNT];
    bit  m_pop = 0;
    bit  m_pe  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit ready_all;
        bit seen_all;
        ready_all = 1;
        for (int b = 0; b < IR_COUNT; b++) if (!i_ir_ready[b]) ready_all = 0;
        for (int b = 0; b < WR_COUNT; b++) if (!i_wr_ready[b]) ready_all = 0;
        if (i_rst || i_reg_clear) begin
            m_phase = P_IDLE; m_total = 0; m_idx = 0; m_drain_left = 0;
            m_pop = 0; m_pe = 0;
            foreach (m_seen[b]) m_seen[b] = 0;
        end else begin
            m_pe  = m_pop;
            m_pop = 0;
            if (m_phase == P_ROUTE || m_phase == P_STREAM) begin
                for (int b = 0; b < IR_COUNT; b++) if (i_ir_done[b]) m_seen[b] = 1;
                for (int b = 0; b < WR_COUNT; b++) if (i_wr_done[b]) m_seen[IR_COUNT+b] = 1;
            end
            seen_all = 1;
            foreach (m_seen[b]) if (!m_seen[b]) seen_all = 0;
            case (m_phase)
                P_IDLE: if (i_start) begin
                    m_total = int'(i_pass_count);
                    m_idx   = 0;
                    foreach (m_seen[b]) m_seen[b] = 0;
                    m_phase = (m_total == 0) ? P_DONE : P_ROUTE;
                end
                P_ROUTE: if (ready_all) m_phase = P_STREAM;
                P_STREAM: begin
                    if (seen_all) begin
                        m_phase = P_DRAIN;
                        m_drain_left = DRAIN_CYC;
                    end else begin
                        m_pop = ready_all;
                    end
                end
                P_DRAIN: begin
                    m_drain_left = m_drain_left - 1;
                    if (m_drain_left == 0) m_phase = (m_idx + 1 == m_total) ? P_DONE : P_REROUTE;
                end
                P_REROUTE: begin
                    foreach (m_seen[b]) m_seen[b] = 0;
                    m_idx   = m_idx + 1;
                    m_phase = P_ROUTE;
                end
                default: m_phase = P_IDLE;
            endcase
        end
    endtask

    task automatic check_all();
        chk("route_en",    32'(o_route_en),    32'(m_phase == P_ROUTE || m_phase == P_STREAM));
        chk("pop",         32'(o_pop),         32'(m_pop));
        chk("pe_en",       32'(o_pe_en),       32'(m_pe));
        chk("psum_out_en", 32'(o_psum_out_en), 32'(m_phase == P_DRAIN));
        chk("reroute",     32'(o_reroute),     32'(m_phase == P_REROUTE));
        chk("array_clear", 32'(o_array_clear), 32'(m_phase == P_REROUTE));
        chk("pass_idx",    32'(o_pass_idx),    32'(m_idx));
        chk("busy",        32'(o_busy),        32'(m_phase >= P_ROUTE && m_phase <= P_REROUTE));
        chk("done",        32'(o_done),        32'(m_phase == P_DONE));
    endtask

    task automatic tick();
        model_step();
        @(posedge i_clk);
        #1;
        check_all();
    endtask

    // Clock until o_done, counting reroute pulses; an expired bound is a failure.
    task automatic wait_done(input int limit, output int rr_cnt, output int last_idx);
        bit got;
        got = 0; rr_cnt = 0; last_idx = -1;
        for (int k = 0; k < limit && !got; k++) begin
            tick();
            if (o_reroute) rr_cnt++;
            if (o_done) begin got = 1; last_idx = int'(o_pass_idx); end
        end
        chk("done_reached", 32'(got), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rr, lidx, popc, dn, clr, cnt;
        bit got;
        int idxq[$];

        foreach (m_seen[b]) m_seen[b] = 0;
        #1;
        tick(); tick();
        i_rst = 1'b0;
        tick();
        chk("reset_busy", 32'(o_busy), 32'd0);

        // Reset mid-STREAM with pop high.
        i_pass_count = 8'd2; i_ir_ready = '1; i_wr_ready = '1; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin tick(); if (o_pop) got = 1; end
        chk("t1_pop_seen", 32'(got), 32'd1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("t1_rst_pop",   32'(o_pop),      32'd0);
        chk("t1_rst_route", 32'(o_route_en), 32'd0);
        chk("t1_rst_pe",    32'(o_pe_en),    32'd0);
        tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0; i_ir_done = '1; i_wr_done = '1;
        wait_done(100, rr, lidx);
        chk("t1_reroutes", 32'(rr), 32'd1);
        chk("t1_last_idx", 32'(lidx), 32'd1);
        i_ir_done = '0; i_wr_done = '0; i_ir_ready = '0; i_wr_ready = '0;
        tick(); tick();

        // Single pass with exact cycle numbering: start in cycle 1, ready from 3, done in 10.
        i_pass_count = 8'd1;
        popc = 0; cnt = 0; dn = 0; rr = 0;
        for (int k = 0; k < 20; k++) begin
            i_start    = (k == 1);
            i_ir_ready = (k >= 3) ? '1 : '0;
            i_wr_ready = (k >= 3) ? '1 : '0;
            i_ir_done  = (k == 10) ? '1 : '0;
            i_wr_done  = (k == 10) ? '1 : '0;
            tick();
            chk("t2_pop_cycle", 32'(o_pop),   32'((k + 1 >= 5) && (k + 1 <= 10)));
            chk("t2_pe_cycle",  32'(o_pe_en), 32'((k + 1 >= 6) && (k + 1 <= 11)));
            if (o_psum_out_en) cnt++;
            if (o_done) dn++;
            if (o_reroute) rr++;
        end
        chk("t2_psum_cycles", 32'(cnt), 32'(DRAIN_CYC));
        chk("t2_done_pulses", 32'(dn), 32'd1);
        chk("t2_reroutes",    32'(rr), 32'd0);
        i_start = 1'b0; i_ir_ready = '0; i_wr_ready = '0;
        tick();

        // Three passes, done bits on alternating cycles, stray start and count change mid-run.
        i_pass_count = 8'd3; i_ir_ready = '1; i_wr_ready = '1;
        rr = 0; clr = 0; dn = 0;
        for (int k = 0; k < 120; k++) begin
            i_start = (k == 0) || (k == 9);
            if (k == 1) i_pass_count = 8'd7;
            i_ir_done = (k % 2 == 0) ? '1 : '0;
            i_wr_done = (k % 2 == 1) ? '1 : '0;
            tick();
            if (o_reroute) rr++;
            if (o_array_clear) clr++;
            if (o_done) dn++;
            if (o_busy && (idxq.size() == 0 || idxq[$] != int'(o_pass_idx)))
                idxq.push_back(int'(o_pass_idx));
        end
        chk("t3_reroutes", 32'(rr),  32'd2);
        chk("t3_clears",   32'(clr), 32'd2);
        chk("t3_done",     32'(dn),  32'd1);
        chk("t3_idx_count", 32'(idxq.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            chk("t3_idx_step", 32'((i < idxq.size()) ? idxq[i] : -1), 32'(i));
        i_start = 1'b0; i_ir_done = '0; i_wr_done = '0;
        tick();

        // Backpressure: weight router ready low for three cycles mid-STREAM.
        i_pass_count = 8'd1; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        for (int k = 0; k < 12; k++) begin
            i_wr_ready = (k >= 2 && k <= 4) ? '0 : '1;
            tick();
            chk("t4_pop", 32'(o_pop),   32'(!(k >= 2 && k <= 4)));
            chk("t4_pe",  32'(o_pe_en), 32'(!(k >= 3 && k <= 5)));
        end
        i_ir_done = '1; i_wr_done = '1;
        wait_done(50, rr, lidx);
        i_ir_done = '0; i_wr_done = '0; i_ir_ready = '0; i_wr_ready = '0;
        tick();

        // Zero passes: done on the next edge, never busy.
        i_pass_count = 8'd0; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("t5_done", 32'(o_done), 32'd1);
        chk("t5_busy", 32'(o_busy), 32'd0);
        tick();
        chk("t5_done_end", 32'(o_done), 32'd0);
        chk("t5_busy_end", 32'(o_busy), 32'd0);

        // Soft clear together with start, then soft clear during drain.
        i_pass_count = 8'd3; i_start = 1'b1; i_reg_clear = 1'b1;
        tick();
        i_start = 1'b0; i_reg_clear = 1'b0;
        chk("t6_idle_busy", 32'(o_busy), 32'd0);
        tick();
        chk("t6_idle_route", 32'(o_route_en), 32'd0);
        i_pass_count = 8'd2; i_ir_ready = '1; i_wr_ready = '1;
        i_ir_done = '1; i_wr_done = '1; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin tick(); if (o_psum_out_en) got = 1; end
        chk("t6_drain_seen", 32'(got), 32'd1);
        i_reg_clear = 1'b1;
        tick();
        i_reg_clear = 1'b0;
        chk("t6_clear_psum", 32'(o_psum_out_en), 32'd0);
        chk("t6_clear_busy", 32'(o_busy), 32'd0);

        // Maximum pass count runs every pass without wrapping.
        i_pass_count = 8'd255; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_done(3000, rr, lidx);
        chk("t7_reroutes", 32'(rr),   32'd254);
        chk("t7_last_idx", 32'(lidx), 32'd254);
        i_ir_done = '0; i_wr_done = '0;
        tick();

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            i_rst       = ($urandom_range(0, 299) == 0);
            i_reg_clear = ($urandom_range(0, 199) == 0);
            i_start     = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 7) == 0) i_pass_count = PASS_WIDTH'($urandom_range(0, 4));
            for (int b = 0; b < IR_COUNT; b++) begin
                i_ir_ready[b] = ($urandom_range(0, 99) < 85);
                i_ir_done[b]  = ($urandom_range(0, 99) < 25);
            end
            for (int b = 0; b < WR_COUNT; b++) begin
                i_wr_ready[b] = ($urandom_range(0, 99) < 85);
                i_wr_done[b]  = ($urandom_range(0, 99) < 25);
            end
            tick();
        end
        i_rst = 1'b0; i_reg_clear = 1'b0; i_start = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
